bomb_ctrl: RTL
==============

Name: bomb_ctrl

Overview:
- Upstream producer for the box/wall stage. It places one bomb on the tile under bomberman and runs its fuse.
- When the fuse expires it detonates, drives the explosion tile location (e_x, e_y) consumed by the box stage, then enforces a cooldown before the next bomb.
- It also produces registered per-pixel bomb and fire overlay flags for the top-level pixel mux.

Parameters:
- TILE, 16, tile edge in pixels; must be a power of two.
- FUSE_TICKS, 150000000, cycles spent in ARMED.
- EXPLODE_TICKS, 50000000, cycles spent in EXPLODE.
- COOLDOWN_TICKS, 25000000, cycles spent in COOLDOWN.
- CNT_W, 28, phase counter width; must hold the largest TICKS value.
- REACH, 48, fire arm length in pixels on the up/left side. The down/right side extends REACH+TILE-1 (63).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted); deasserted synchronously by system.
- place_btn  in  1  debounced, synchronous level; its rising edge requests a bomb.
- b_x  in  10  bomberman x, top-left pixel.
- b_y  in  10  bomberman y, top-left pixel.
- v_x  in  10  current VGA pixel x.
- v_y  in  10  current VGA pixel y.
- bomb_active  out  1  high in ARMED.
- bomb_x  out  10  latched bomb tile x, grid-aligned.
- bomb_y  out  10  latched bomb tile y, grid-aligned.
- exploding  out  1  high in EXPLODE.
- explode_start  out  1  one-cycle pulse on the first EXPLODE cycle.
- e_x  out  10  explosion tile x; 10'd800 when not exploding.
- e_y  out  10  explosion tile y; 10'd600 when not exploding.
- bomb_pix_on  out  1  registered; the current pixel is inside the armed bomb tile.
- fire_pix_on  out  1  registered; the current pixel is inside the explosion cross.

Behaviour:
- Reset values:
  - state = IDLE, counter = 0, btn_q = 0.
  - bomb_x, bomb_y = 0; bomb_active, exploding, explode_start, bomb_pix_on, fire_pix_on = 0.
  - e_x = 800, e_y = 600.
- Reset asserted mid-operation aborts everything immediately; no pulse is emitted.
- Edge detect: press = place_btn & ~btn_q; btn_q <= place_btn every cycle.
  - A held button never re-triggers.
  - press is acted on only in IDLE and is silently dropped in all other states.
- Snap rule: bomb_x <= (b_x + TILE/2) & ~(TILE-1), and likewise for y, using an 11-bit intermediate.
  - Example: b_x = 167 gives 160; b_x = 168 gives 176.
  - The result is clamped to 624 (x) and 464 (y).
- FSM:
  - IDLE: on press, latch bomb_x/bomb_y, counter <= 0, go to ARMED. bomb_active is high from the next cycle.
  - ARMED: counter increments each cycle. When counter == FUSE_TICKS-1, set counter <= 0 and go to EXPLODE, so ARMED lasts exactly FUSE_TICKS cycles. On entry to EXPLODE: e_x/e_y <= bomb_x/bomb_y, exploding <= 1, explode_start <= 1 for one cycle, bomb_active <= 0.
  - EXPLODE: lasts exactly EXPLODE_TICKS cycles. On exit: e_x/e_y return to the sentinels, exploding <= 0, go to COOLDOWN.
  - COOLDOWN: lasts exactly COOLDOWN_TICKS cycles, then go to IDLE. A press arriving in the same cycle as the COOLDOWN→IDLE transition is dropped.
- The sentinels 800/600 keep e_x-48 .. e_x+63 and e_y-48 .. e_y+63 entirely off-screen with no 10-bit wrap.
- Pixel overlays have 1-cycle latency, matching the box stage. All comparisons use addition only, so there is no underflow.
  - bomb_pix_on <= bomb_active && v_x >= bomb_x && v_x < bomb_x+TILE && v_y >= bomb_y && v_y < bomb_y+TILE.
  - fire_pix_on <= exploding && (H || V), where:
    - H = v_y in [e_y, e_y+TILE) && v_x+REACH >= e_x && v_x <= e_x+REACH+TILE-1.
    - V = v_x in [e_x, e_x+TILE) && v_y+REACH >= e_y && v_y <= e_y+REACH+TILE-1.
  - Use an 11-bit intermediate for all sums.

Optional Feature:
- Macro: BOMB_REMOTE_DET_EN.
- With the macro: a press while ARMED forces the ARMED→EXPLODE transition on that same clock edge. The transition has identical entry actions, including explode_start. If a press lands exactly on the natural expiry cycle, only one transition occurs.
- Without the macro: presses in ARMED are ignored and the fuse always runs its full length.

Decomposition:
- Package bomb_pkg holds:
  - the state encoding: IDLE=2'd0, ARMED=2'd1, EXPLODE=2'd2, COOLDOWN=2'd3;
  - E_OFF_X=10'd800, E_OFF_Y=10'd600;
  - the default TILE and REACH.
- One sub-module, rise_edge, holds the btn_q register and the press output (clk/reset as above). The FSM, counter and overlay logic stay in bomb_ctrl.

Test Plan:
- Test parameters for all scenarios: FUSE=10, EXPLODE=4, COOLDOWN=3.
- Placement and fuse: b_x=167, b_y=72, one press → bomb_x=160, bomb_y=80, bomb_active high for exactly 10 cycles, then explode_start for 1 cycle and e_x=160, e_y=80 with exploding high for exactly 4 cycles. Afterwards e_x/e_y = 800/600.
- Dropped presses: place_btn held high continuously → exactly one bomb cycle. Presses during ARMED/EXPLODE/COOLDOWN → no new bomb. A press at the first IDLE cycle → a new bomb.
- Overlays during EXPLODE at e=(160,80):
  - pixel (112,85) → fire_pix_on=1 one cycle later.
  - (111,85) → 0.
  - (223,85) → 1.
  - (224,85) → 0.
  - (165,143) → 1.
  - (170,70) → 1.
  - (100,100) → 0.
- Edge clamp: b_x=639, b_y=479 → bomb_x=624, bomb_y=464. bomb_pix_on=1 at (639,479); e_x+63 causes no wrap.
- Reset abort: assert reset at the 5th ARMED cycle → all outputs at reset values asynchronously. After release, the next press starts a fresh 10-cycle fuse.
- With BOMB_REMOTE_DET_EN: second press at ARMED cycle 3 → explode_start on that edge. Without the macro: full 10-cycle fuse.

Source files
------------

// File: rtl/bomb_pkg.sv
// bomb_pkg: shared definitions for the bomb controller.
//   - state_t     : FSM encoding (IDLE, ARMED, EXPLODE, COOLDOWN)
//   - E_OFF_X/Y   : off-screen sentinel explosion location
//   - TILE_DEF    : default tile edge in pixels
//   - REACH_DEF   : default fire arm length on the up/left side
//   - snap_coord  : rounds a sprite coordinate to the nearest tile origin
package bomb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    EXPLODE  = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  // Far enough off a 640x480 screen that e-48 .. e+63 never wraps 10 bits
  localparam logic [9:0] E_OFF_X = 10'd800;
  localparam logic [9:0] E_OFF_Y = 10'd600;

  localparam int TILE_DEF  = 16;
  localparam int REACH_DEF = 48;

  // (p + half) & mask in 11 bits, then clamped to the last tile origin.
  function automatic logic [9:0] snap_coord(input logic [9:0]  p,
                                            input logic [10:0] half,
                                            input logic [10:0] mask,
                                            input logic [10:0] max_org);
    logic [10:0] aligned;
    aligned = ({1'b0, p} + half) & mask;
    if (aligned > max_org) aligned = max_org;
    return aligned[9:0];
  endfunction

endpackage

// File: rtl/bomb_ctrl_rise_edge.sv
// rise_edge: rising-edge detector for the place button.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   level : synchronous debounced level input
//   press : high for the cycle in which level rises
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic press
);

  logic btn_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) btn_q <= 1'b0;
    else        btn_q <= level;
  end

  assign press = level & ~btn_q;

endmodule

// File: rtl/bomb_ctrl.sv
// bomb_ctrl: places a single bomb on the tile under bomberman, runs its
// fuse, drives the explosion tile to the box stage, then cools down.
// Also produces registered per-pixel bomb/fire overlay flags.
//
// Ports:
//   clk, reset (async active-low)
//   place_btn        : debounced level, rising edge requests a bomb
//   b_x, b_y         : bomberman top-left pixel
//   v_x, v_y         : current VGA pixel
//   bomb_active      : high in ARMED
//   bomb_x, bomb_y   : latched grid-aligned bomb tile
//   exploding        : high in EXPLODE
//   explode_start    : one-cycle pulse on the first EXPLODE cycle
//   e_x, e_y         : explosion tile, 800/600 when not exploding
//   bomb_pix_on      : pixel inside armed bomb tile (1-cycle latency)
//   fire_pix_on      : pixel inside explosion cross (1-cycle latency)
//
// Build option: define BOMB_REMOTE_DET_EN to let a press during ARMED
// detonate the bomb immediately.
module bomb_ctrl
  import bomb_pkg::*;
#(
  parameter int TILE           = TILE_DEF,
  parameter int FUSE_TICKS     = 150000000,
  parameter int EXPLODE_TICKS  = 50000000,
  parameter int COOLDOWN_TICKS = 25000000,
  parameter int CNT_W          = 28,
  parameter int REACH          = REACH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       place_btn,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  input  logic [9:0] v_x,
  input  logic [9:0] v_y,
  output logic       bomb_active,
  output logic [9:0] bomb_x,
  output logic [9:0] bomb_y,
  output logic       exploding,
  output logic       explode_start,
  output logic [9:0] e_x,
  output logic [9:0] e_y,
  output logic       bomb_pix_on,
  output logic       fire_pix_on
);

  localparam logic [10:0] HALF      = 11'(TILE / 2);
  localparam logic [10:0] ALIGN     = ~(11'(TILE - 1));
  localparam logic [10:0] X_MAX     = 11'(640 - TILE);
  localparam logic [10:0] Y_MAX     = 11'(480 - TILE);
  localparam logic [10:0] TILE11    = 11'(TILE);
  localparam logic [10:0] REACH11   = 11'(REACH);
  localparam logic [10:0] FAR11     = 11'(REACH + TILE - 1);

  localparam logic [CNT_W-1:0] FUSE_LAST = CNT_W'(FUSE_TICKS - 1);
  localparam logic [CNT_W-1:0] EXP_LAST  = CNT_W'(EXPLODE_TICKS - 1);
  localparam logic [CNT_W-1:0] CD_LAST   = CNT_W'(COOLDOWN_TICKS - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             press;
  logic             remote_det;
  logic [9:0]       snap_x;
  logic [9:0]       snap_y;

  rise_edge u_rise_edge (
    .clk   (clk),
    .reset (reset),
    .level (place_btn),
    .press (press)
  );

`ifdef BOMB_REMOTE_DET_EN
  assign remote_det = press;
`else
  assign remote_det = 1'b0;
`endif

  assign snap_x = snap_coord(b_x, HALF, ALIGN, X_MAX);
  assign snap_y = snap_coord(b_y, HALF, ALIGN, Y_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      counter       <= '0;
      bomb_active   <= 1'b0;
      bomb_x        <= '0;
      bomb_y        <= '0;
      exploding     <= 1'b0;
      explode_start <= 1'b0;
      e_x           <= E_OFF_X;
      e_y           <= E_OFF_Y;
    end else begin
      explode_start <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            bomb_x      <= snap_x;
            bomb_y      <= snap_y;
            counter     <= '0;
            bomb_active <= 1'b1;
            state       <= ARMED;
          end
        end
        ARMED: begin
          // Natural expiry and a remote press on the same edge collapse
          // into a single transition.
          if (counter == FUSE_LAST || remote_det) begin
            counter       <= '0;
            e_x           <= bomb_x;
            e_y           <= bomb_y;
            exploding     <= 1'b1;
            explode_start <= 1'b1;
            bomb_active   <= 1'b0;
            state         <= EXPLODE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        EXPLODE: begin
          if (counter == EXP_LAST) begin
            counter   <= '0;
            e_x       <= E_OFF_X;
            e_y       <= E_OFF_Y;
            exploding <= 1'b0;
            state     <= COOLDOWN;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        COOLDOWN: begin
          if (counter == CD_LAST) begin
            counter <= '0;
            state   <= IDLE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Overlay comparisons: all in 11 bits and addition-only so the
  // up/left arms never underflow.
  logic [10:0] vx11, vy11, bx11, by11, ex11, ey11;
  logic        in_bomb, h_arm, v_arm;

  assign vx11 = {1'b0, v_x};
  assign vy11 = {1'b0, v_y};
  assign bx11 = {1'b0, bomb_x};
  assign by11 = {1'b0, bomb_y};
  assign ex11 = {1'b0, e_x};
  assign ey11 = {1'b0, e_y};

  assign in_bomb = (vx11 >= bx11) && (vx11 < bx11 + TILE11) &&
                   (vy11 >= by11) && (vy11 < by11 + TILE11);
  assign h_arm   = (vy11 >= ey11) && (vy11 < ey11 + TILE11) &&
                   (vx11 + REACH11 >= ex11) && (vx11 <= ex11 + FAR11);
  assign v_arm   = (vx11 >= ex11) && (vx11 < ex11 + TILE11) &&
                   (vy11 + REACH11 >= ey11) && (vy11 <= ey11 + FAR11);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bomb_pix_on <= 1'b0;
      fire_pix_on <= 1'b0;
    end else begin
      bomb_pix_on <= bomb_active && in_bomb;
      fire_pix_on <= exploding && (h_arm || v_arm);
    end
  end

endmodule
